// File: rtl/decode_compact_stage.sv
// Decode-to-instruction-buffer stage: packs sparse slot masks into a prefix and
// buffers groups in an output register plus one skid entry. Optional: DECODE_COMPACT_PERF_EN.
`ifndef FETCH_BANDWIDTH
`define FETCH_BANDWIDTH 4
`endif
`ifndef SIZE_SPECIAL_REG
`define SIZE_SPECIAL_REG 32
`endif
`ifndef LDST_TYPES_LOG
`define LDST_TYPES_LOG 3
`endif
`ifndef INST_TYPES_LOG
`define INST_TYPES_LOG 2
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 5
`endif
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 2
`endif

module decode_compact_stage #(
  parameter int unsigned SLOTS = 2*`FETCH_BANDWIDTH,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned PKT_W = 2*`SIZE_SPECIAL_REG+3+`LDST_TYPES_LOG+`INST_TYPES_LOG+
                                 `SIZE_IMMEDIATE+1+3*`SIZE_RMT_LOG+3+`SIZE_OPCODE_I+
                                 2*`SIZE_PC+`SIZE_CTI_LOG+1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  logic [SLOTS-1:0]       vector_i,
  input  logic [SLOTS*PKT_W-1:0] packet_i,
  output logic                   ready_o,
  input  logic                   stallFetch_i,
  output logic                   decodeReady_o,
  output logic [SLOTS-1:0]       decodedVector_o,
  output logic [SLOTS*PKT_W-1:0] packet_o
`ifdef DECODE_COMPACT_PERF_EN
  ,
  output logic [31:0]            perfStallCount_o
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e                 state_q, state_d;
  logic [SLOTS*PKT_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [SLOTS-1:0]       out_mask_q, out_mask_d, skid_mask_q, skid_mask_d;
  logic                   ready_q, ready_d;

  logic [SLOTS*PKT_W-1:0] comp_data;
  logic [SLOTS-1:0]       comp_mask;
  logic [CNT_W-1:0]       pop;
  logic                   acc, fire, out_valid;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    comp_data = '0;
    comp_mask = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (vector_i[s]) begin
        comp_data[idx*PKT_W +: PKT_W] = packet_i[s*PKT_W +: PKT_W];
        idx = idx + 1;
      end
    end
    pop = CNT_W'(idx);
    for (int unsigned j = 0; j < SLOTS; j++) begin
      comp_mask[j] = (CNT_W'(j) < pop);
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign acc       = valid_i & ready_q & (|vector_i);
  assign fire      = out_valid & ~stallFetch_i;

  // Skid only fills while out is stalled, so ready_q low means skid is occupied.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    skid_data_d = skid_data_q;
    skid_mask_d = skid_mask_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            out_data_d = comp_data;
            out_mask_d = comp_mask;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (fire) begin
            if (acc) begin
              out_data_d = comp_data;
              out_mask_d = comp_mask;
            end else begin
              state_d = EMPTY;
            end
          end else if (acc) begin
            skid_data_d = comp_data;
            skid_mask_d = comp_mask;
            state_d     = FULL;
          end
        end
        FULL: begin
          if (fire) begin
            out_data_d = skid_data_q;
            out_mask_d = skid_mask_q;
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      skid_data_q <= '0;
      skid_mask_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      skid_data_q <= skid_data_d;
      skid_mask_q <= skid_mask_d;
      ready_q     <= ready_d;
    end
  end

  assign ready_o         = ready_q;
  assign decodeReady_o   = out_valid;
  assign decodedVector_o = out_valid ? out_mask_q : '0;
  assign packet_o        = out_data_q;

`ifdef DECODE_COMPACT_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (out_valid && stallFetch_i && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perfStallCount_o = perf_q;
`endif

endmodule

// File: tb/tb_decode_compact_stage.sv
// Directed bench for decode_compact_stage (SLOTS=8, PKT_W=16): compaction table
// plus stall/skid, flush, empty-group, async-reset and optional perf-counter sequences.
module tb_decode_compact_stage;

  localparam int unsigned SLOTS = 8;
  localparam int unsigned PKT_W = 16;
  localparam int unsigned W     = SLOTS*PKT_W;

  logic             clk, reset, flush_i, valid_i, stallFetch_i;
  logic [SLOTS-1:0] vector_i;
  logic [W-1:0]     packet_i;
  logic             ready_o, decodeReady_o;
  logic [SLOTS-1:0] decodedVector_o;
  logic [W-1:0]     packet_o;
`ifdef DECODE_COMPACT_PERF_EN
  logic [31:0]      perfStallCount_o;
`endif

  decode_compact_stage #(.SLOTS(SLOTS), .CNT_W(4), .PKT_W(PKT_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .vector_i(vector_i),
    .packet_i(packet_i),
    .ready_o(ready_o),
    .stallFetch_i(stallFetch_i),
    .decodeReady_o(decodeReady_o),
    .decodedVector_o(decodedVector_o),
    .packet_o(packet_o)
`ifdef DECODE_COMPACT_PERF_EN
    ,
    .perfStallCount_o(perfStallCount_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // src nibble j = source slot for output slot j; F = slot must be zero
  typedef struct {
    logic [7:0]  vec;
    logic [7:0]  mask;
    logic [31:0] src;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] vec, input logic [15:0] base);
    valid_i  = 1'b1;
    vector_i = vec;
    for (int s = 0; s < SLOTS; s++) packet_i[s*PKT_W +: PKT_W] = base + 16'(s);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] expd;
    logic [3:0]   nib;
    logic [15:0]  base;

    tbl[0] = '{8'hA5, 8'h0F, 32'hFFFF7520};
    tbl[1] = '{8'hFF, 8'hFF, 32'h76543210};
    tbl[2] = '{8'h80, 8'h01, 32'hFFFFFFF7};
    tbl[3] = '{8'h01, 8'h01, 32'hFFFFFFF0};
    tbl[4] = '{8'h68, 8'h07, 32'hFFFFF653};
    tbl[5] = '{8'hFE, 8'h7F, 32'hF7654321};
    tbl[6] = '{8'h82, 8'h03, 32'hFFFFFF71};

    reset = 1'b1; flush_i = 1'b0; valid_i = 1'b0; stallFetch_i = 1'b0;
    vector_i = '0; packet_i = '0;
    #12;
    chk("rst_decodeReady", W'(decodeReady_o), W'(1'b0));
    chk("rst_vector", W'(decodedVector_o), '0);
    chk("rst_packet", packet_o, '0);
    chk("rst_ready", W'(ready_o), W'(1'b1));
`ifdef DECODE_COMPACT_PERF_EN
    chk("rst_perf", W'(perfStallCount_o), '0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Compaction table, one group per cycle, back to back
    for (int i = 0; i < 7; i++) begin
      base = 16'((i + 1) * 16'h1000);
      drive(tbl[i].vec, base);
      tick();
      expd = '0;
      for (int j = 0; j < SLOTS; j++) begin
        nib = tbl[i].src[j*4 +: 4];
        if (nib != 4'hF) expd[j*PKT_W +: PKT_W] = base + 16'(nib);
      end
      chk($sformatf("tbl%0d_mask", i), W'(decodedVector_o), W'(tbl[i].mask));
      chk($sformatf("tbl%0d_pkt", i), packet_o, expd);
      chk($sformatf("tbl%0d_ready", i), W'(ready_o), W'(1'b1));
    end

    // Async reset mid-cycle with a group on the outputs
    valid_i = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_decodeReady", W'(decodeReady_o), W'(1'b0));
    chk("async_rst_vector", W'(decodedVector_o), '0);
    chk("async_rst_ready", W'(ready_o), W'(1'b1));
    @(posedge clk); #1;
    reset = 1'b0;

    // Stall and skid: A, B, C offered back to back under a 3-cycle stall
    stallFetch_i = 1'b1;
    drive(8'h0C, 16'hA000);
    tick();
    drive(8'h10, 16'hB000);
    tick();
    chk("stall1_vector", W'(decodedVector_o), W'(8'h03));
    chk("stall1_ready", W'(ready_o), W'(1'b0));
    drive(8'hC0, 16'hC000);
    tick();
    chk("stall2_pkt_A", packet_o, {96'b0, 16'hA003, 16'hA002});
    chk("stall2_ready", W'(ready_o), W'(1'b0));
    stallFetch_i = 1'b0;
    tick();
    chk("rel_B_vector", W'(decodedVector_o), W'(8'h01));
    chk("rel_B_pkt", packet_o, {112'b0, 16'hB004});
    chk("rel_B_ready", W'(ready_o), W'(1'b1));
    tick();
    chk("rel_C_vector", W'(decodedVector_o), W'(8'h03));
    chk("rel_C_pkt", packet_o, {96'b0, 16'hC007, 16'hC006});
    valid_i = 1'b0;
    tick();
    chk("rel_drain", W'(decodeReady_o), W'(1'b0));

    // Flush from FULL
    stallFetch_i = 1'b1;
    drive(8'h01, 16'hD000);
    tick();
    drive(8'h02, 16'hE000);
    tick();
    chk("pre_flush_ready", W'(ready_o), W'(1'b0));
    flush_i = 1'b1;
    drive(8'h04, 16'hF000);
    tick();
    flush_i = 1'b0; valid_i = 1'b0; stallFetch_i = 1'b0;
    chk("flush_decodeReady", W'(decodeReady_o), W'(1'b0));
    chk("flush_ready", W'(ready_o), W'(1'b1));
    chk("flush_vector", W'(decodedVector_o), '0);
    tick();
    chk("flush_no_ghost", W'(decodeReady_o), W'(1'b0));

    // Flush from ONE: group offered while ready=1 must still be dropped
    drive(8'h01, 16'h5000);
    tick();
    flush_i = 1'b1;
    drive(8'h08, 16'h6000);
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_one_drop", W'(decodeReady_o), W'(1'b0));
    tick();
    chk("flush_one_still_empty", W'(decodeReady_o), W'(1'b0));

    // Empty group is consumed without creating an entry
    drive(8'h00, 16'h7000);
    tick();
    valid_i = 1'b0;
    chk("empty_ready", W'(ready_o), W'(1'b1));
    chk("empty_decodeReady", W'(decodeReady_o), W'(1'b0));

`ifdef DECODE_COMPACT_PERF_EN
    reset = 1'b1;
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    drive(8'h01, 16'h9000);
    tick();
    valid_i = 1'b0;
    stallFetch_i = 1'b1;
    repeat (5) tick();
    chk("perf_5", W'(perfStallCount_o), W'(32'd5));
    stallFetch_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("perf_after_flush", W'(perfStallCount_o), W'(32'd5));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
